// File: rtl/aes_subbytes_ctrl.sv
// aes_subbytes_ctrl
//   Sequences a 2-share masked AES state, one byte per cycle, through an
//   external pipelined 2-share S-box. It then reassembles the substituted
//   shares and supplies fresh mask randomness from a 32-bit Galois LFSR.
//
// Ports
//   clock, resetn           rising-edge clock, async active-low reset
//   start                   begin an operation (sampled in IDLE only)
//   state_in0/1   [127:0]   input shares, byte 0 = [127:120]
//   seed_load, seed[31:0]   load LFSR seed (IDLE only, zero -> 1)
//   sbox_in0/1    [7:0]     byte shares to S-box (zero outside FEED)
//   mask_out      [15:0]    LFSR low half, to S-box mask_in
//   sbox_out0/1   [7:0]     S-box result shares, SBOX_LAT cycles later
//   busy                    high from the start edge until done
//   done                    one-cycle pulse, state_out0/1 complete
//   state_out0/1  [127:0]   substituted shares, held until next done
//
// Share 0 and share 1 live in separate registers throughout. No logic
// combines them.
module aes_subbytes_ctrl #(
  parameter int SBOX_LAT = 5
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] state_in0,
  input  logic [127:0] state_in1,
  input  logic         seed_load,
  input  logic [31:0]  seed,
  output logic [7:0]   sbox_in0,
  output logic [7:0]   sbox_in1,
  output logic [15:0]  mask_out,
  input  logic [7:0]   sbox_out0,
  input  logic [7:0]   sbox_out1,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out0,
  output logic [127:0] state_out1
);

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t              state_q;
  logic [3:0]          feed_cnt_q;
  logic [3:0]          cap_cnt_q;
  logic [127:0]        sh0_q, sh1_q;     // input shares, shifted left per byte
  logic [127:0]        acc0_q, acc1_q;   // results gathered during an op
  logic [127:0]        out0_q, out1_q;   // published results
  logic [SBOX_LAT-1:0] vld_pipe_q;       // one bit per byte in the S-box
  logic                busy_q, done_q;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                issue, cap;

  // Both shifters fill with zeros, so they are already empty once the
  // 16th byte has gone out. That empty state is the idle-zero drive.
  assign sbox_in0   = sh0_q[127:120];
  assign sbox_in1   = sh1_q[127:120];
  assign mask_out   = lfsr_q[15:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_out0 = out0_q;
  assign state_out1 = out1_q;

  assign issue = (state_q == FEED);
  assign cap   = vld_pipe_q[SBOX_LAT-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      feed_cnt_q <= '0;
      cap_cnt_q  <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      acc0_q     <= '0;
      acc1_q     <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      vld_pipe_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      vld_pipe_q[0] <= issue;
      for (int i = 1; i < SBOX_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];

      // The oldest valid bit marks an S-box result for the next byte in
      // issue order, so the results shift in behind one another.
      if (cap) begin
        acc0_q    <= {acc0_q[119:0], sbox_out0};
        acc1_q    <= {acc1_q[119:0], sbox_out1};
        cap_cnt_q <= cap_cnt_q + 4'd1;
        if (cap_cnt_q == 4'd15) begin
          out0_q  <= {acc0_q[119:0], sbox_out0};
          out1_q  <= {acc1_q[119:0], sbox_out1};
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            sh0_q      <= state_in0;
            sh1_q      <= state_in1;
            feed_cnt_q <= '0;
            cap_cnt_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= FEED;
          end
        end
        FEED: begin
          sh0_q      <= {sh0_q[119:0], 8'h00};
          sh1_q      <= {sh1_q[119:0], 8'h00};
          feed_cnt_q <= feed_cnt_q + 4'd1;
          if (feed_cnt_q == 4'd15) state_q <= DRAIN;
        end
        default: ;  // DRAIN leaves through the final capture above
      endcase
    end
  end

  // Right-shift Galois LFSR. It free-runs except on a seed load in IDLE.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    if (seed_load && state_q == IDLE)
      lfsr_d = (seed == 32'h0) ? 32'h00000001 : seed;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) lfsr_q <= 32'h00000001;
    else         lfsr_q <= lfsr_d;
  end

endmodule

// File: tb/tb_aes_subbytes_ctrl.sv
// Bench for aes_subbytes_ctrl. A behavioural 2-share S-box with the
// default latency sits behind the DUT. It returns
// (S(a0^a1) ^ m, m), where m is taken from mask_out.
module tb_aes_subbytes_ctrl;
  localparam int LAT = 5;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [127:0] state_in0 = '0, state_in1 = '0;
  logic         seed_load = 1'b0;
  logic [31:0]  seed = '0;
  logic [7:0]   sbox_in0, sbox_in1, sbox_out0, sbox_out1;
  logic [15:0]  mask_out;
  logic         busy, done;
  logic [127:0] state_out0, state_out1;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  aes_subbytes_ctrl #(.SBOX_LAT(LAT)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .state_in0(state_in0), .state_in1(state_in1),
    .seed_load(seed_load), .seed(seed),
    .sbox_in0(sbox_in0), .sbox_in1(sbox_in1), .mask_out(mask_out),
    .sbox_out0(sbox_out0), .sbox_out1(sbox_out1),
    .busy(busy), .done(done),
    .state_out0(state_out0), .state_out1(state_out1)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] r, s;
    for (int i = 1; i < 256; i++)
      if (gmul(x, i[7:0]) == 8'h01) inv = i[7:0];
    s = inv;
    r = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Behavioural S-box pipeline.
  logic [7:0] p0 [LAT];
  logic [7:0] p1 [LAT];
  initial for (int i = 0; i < LAT; i++) begin p0[i] = 8'h00; p1[i] = 8'h00; end
  always @(posedge clock) begin
    p0[0] <= sbox(sbox_in0 ^ sbox_in1) ^ mask_out[7:0];
    p1[0] <= mask_out[7:0];
    for (int i = 1; i < LAT; i++) begin p0[i] <= p0[i-1]; p1[i] <= p1[i-1]; end
  end
  assign sbox_out0 = p0[LAT-1];
  assign sbox_out1 = p1[LAT-1];

  localparam logic [127:0] PLAIN_A = 128'h00015302030405060708090a0b0c0dff;
  localparam logic [127:0] EXP_A   = 128'h637ced777bf26b6fc53001672bfed716;
  localparam logic [127:0] PLAIN_B = {8{16'h1020}};
  localparam logic [127:0] EXP_B   = {8{16'hcab7}};

  // Call at a negedge. On return we are at the negedge after start edge T0.
  task automatic launch(input logic [127:0] a0, input logic [127:0] a1);
    state_in0 = a0;
    state_in1 = a1;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // n counts negedges after T0. done must be seen after edge T21, so n == 21.
  task automatic wait_done(input bit poke, input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      nvec++;
      if (busy !== 1'b1) begin nerr++; $display("FAIL busy_n%0d got %b want 1", n, busy); end
      start = poke && (n == 4 || n == 9);
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    nvec++;
    if (n != 21) begin nerr++; $display("FAIL done_cycle got %0d want 21", n); end
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL busy_at_done got %b want 0", busy); end
  endtask

  task automatic test_reset;
    nvec++;
    if ({busy, done, sbox_in0, sbox_in1} !== 18'h0) begin
      nerr++; $display("FAIL reset_ctl got %h want 0", {busy, done, sbox_in0, sbox_in1});
    end
    nvec++;
    if ((state_out0 | state_out1) !== 128'h0) begin
      nerr++; $display("FAIL reset_out got %h/%h want 0", state_out0, state_out1);
    end
    nvec++;
    if (mask_out !== 16'h0001) begin nerr++; $display("FAIL reset_mask got %h want 0001", mask_out); end
  endtask

  task automatic test_zero;
    int n;
    launch('0, '0);
    wait_done(1'b0, 0, n);
    nvec++;
    if ((state_out0 ^ state_out1) !== {16{8'h63}}) begin
      nerr++; $display("FAIL zero_result got %h want %h", state_out0 ^ state_out1, {16{8'h63}});
    end
    @(negedge clock);
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL done_pulse got %b want 0", done); end
    nvec++;
    if ({sbox_in0, sbox_in1} !== 16'h0) begin nerr++; $display("FAIL idle_sbox_in got %h want 0", {sbox_in0, sbox_in1}); end
    nvec++;
    if ((state_out0 ^ state_out1) !== {16{8'h63}}) begin
      nerr++; $display("FAIL zero_hold got %h", state_out0 ^ state_out1);
    end
  endtask

  task automatic test_fips;
    int n;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    launch(r, r ^ PLAIN_A);
    nvec++;
    if ({sbox_in0, sbox_in1} !== {r[127:120], r[127:120] ^ PLAIN_A[127:120]}) begin
      nerr++; $display("FAIL byte0_issue got %h want %h", {sbox_in0, sbox_in1}, {r[127:120], r[127:120] ^ PLAIN_A[127:120]});
    end
    wait_done(1'b0, 0, n);
    nvec++;
    if ((state_out0 ^ state_out1) !== EXP_A) begin
      nerr++; $display("FAIL fips_result got %h want %h", state_out0 ^ state_out1, EXP_A);
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    launch(r, r ^ PLAIN_B);
    state_in0 = ~r;  // a re-accepted start would substitute this instead
    state_in1 = r;
    wait_done(1'b1, 0, n);
    nvec++;
    if ((state_out0 ^ state_out1) !== EXP_B) begin
      nerr++; $display("FAIL busy_start_result got %h want %h", state_out0 ^ state_out1, EXP_B);
    end
    repeat (6) begin
      @(negedge clock);
      nvec++;
      if (done !== 1'b0) begin nerr++; $display("FAIL extra_done got %b want 0", done); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    launch(r, r ^ PLAIN_A);
    wait_done(1'b0, 0, n);
    nvec++;
    if ((state_out0 ^ state_out1) !== EXP_A) begin
      nerr++; $display("FAIL b2b_first got %h want %h", state_out0 ^ state_out1, EXP_A);
    end
    // Still in the done cycle: start again right away.
    launch(~r, ~r ^ PLAIN_B);
    nvec++;
    if (busy !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL b2b_accept got busy=%b done=%b want 1/0", busy, done); end
    nvec++;
    if ((state_out0 ^ state_out1) !== EXP_A) begin
      nerr++; $display("FAIL b2b_hold got %h want %h", state_out0 ^ state_out1, EXP_A);
    end
    wait_done(1'b0, 0, n);
    nvec++;
    if ((state_out0 ^ state_out1) !== EXP_B) begin
      nerr++; $display("FAIL b2b_second got %h want %h", state_out0 ^ state_out1, EXP_B);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    launch(r, r ^ PLAIN_B);
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    #1;
    nvec++;
    if ({busy, done, sbox_in0, sbox_in1} !== 18'h0) begin
      nerr++; $display("FAIL midrst_ctl got %h want 0", {busy, done, sbox_in0, sbox_in1});
    end
    nvec++;
    if ((state_out0 | state_out1) !== 128'h0) begin
      nerr++; $display("FAIL midrst_out got %h/%h want 0", state_out0, state_out1);
    end
    @(negedge clock);
    resetn = 1'b1;
    n = 0;
    repeat (25) begin
      @(negedge clock);
      if (done === 1'b1) n++;
    end
    nvec++;
    if (n != 0) begin nerr++; $display("FAIL midrst_nodone got %0d pulses want 0", n); end
    launch(~r, ~r ^ PLAIN_A);
    wait_done(1'b0, 0, n);
    nvec++;
    if ((state_out0 ^ state_out1) !== EXP_A) begin
      nerr++; $display("FAIL midrst_after got %h want %h", state_out0 ^ state_out1, EXP_A);
    end
  endtask

  task automatic test_lfsr;
    int n;
    logic [31:0] g;
    seed = 32'h0;
    seed_load = 1'b1;
    @(posedge clock);
    @(negedge clock);
    seed_load = 1'b0;
    g = 32'h00000001;
    nvec++;
    if (mask_out !== g[15:0]) begin nerr++; $display("FAIL seed0_load got %h want %h", mask_out, g[15:0]); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      g = lfsr_step(g);
      nvec++;
      if (mask_out !== g[15:0]) begin nerr++; $display("FAIL lfsr_step%0d got %h want %h", i, mask_out, g[15:0]); end
    end
    // Seed load and start on the same edge.
    seed = 32'h1234abcd;
    seed_load = 1'b1;
    launch(128'h0, PLAIN_A);
    seed_load = 1'b0;
    g = 32'h1234abcd;
    nvec++;
    if (mask_out !== g[15:0] || busy !== 1'b1) begin
      nerr++; $display("FAIL seed_start got mask=%h busy=%b want %h/1", mask_out, busy, g[15:0]);
    end
    // A seed load while busy must be ignored.
    seed = 32'hdeadbeef;
    seed_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      g = lfsr_step(g);
      nvec++;
      if (mask_out !== g[15:0]) begin nerr++; $display("FAIL busy_seed%0d got %h want %h", i, mask_out, g[15:0]); end
    end
    seed_load = 1'b0;
    wait_done(1'b0, 3, n);
    nvec++;
    if ((state_out0 ^ state_out1) !== EXP_A) begin
      nerr++; $display("FAIL seed_op_result got %h want %h", state_out0 ^ state_out1, EXP_A);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset;
    resetn = 1'b1;
    @(negedge clock);
    test_zero;
    test_fips;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid;
    test_lfsr;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_ctrl.md
AES_SUBBYTES_CTRL -- requirements
Module: aes_subbytes_ctrl

Interface
REQ-001 SHALL have parameter: SBOX_LAT, default 5, register stages from sbox_in* to sbox_out* of the attached 2-share S-box.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  begin SubBytes on the presented state; sampled in IDLE only.
REQ-005 SHALL have port: state_in0  input  128  state share 0; byte 0 = [127:120].
REQ-006 SHALL have port: state_in1  input  128  state share 1, same layout.
REQ-007 SHALL have port: seed_load  input  1  load seed into the mask LFSR; honoured in IDLE only.
REQ-008 SHALL have port: seed  input  32  LFSR seed.
REQ-009 SHALL have port: sbox_in0  output  8  byte share 0 to the S-box.
REQ-010 SHALL have port: sbox_in1  output  8  byte share 1 to the S-box.
REQ-011 SHALL have port: mask_out  output  16  fresh randomness to the S-box mask_in.
REQ-012 SHALL have port: sbox_out0  input  8  S-box result share 0.
REQ-013 SHALL have port: sbox_out1  input  8  S-box result share 1.
REQ-014 SHALL have port: busy  output  1  high from the edge sampling start until done.
REQ-015 SHALL have port: done  output  1  one-cycle pulse; state_out* complete.
REQ-016 SHALL have port: state_out0  output  128  substituted state share 0.
REQ-017 SHALL have port: state_out1  output  128  substituted state share 1.

Function
REQ-018 SHALL implement FSM IDLE -> FEED (start=1 at an edge) -> DRAIN (after 16th byte issued) -> IDLE (16th result captured, done=1).
REQ-019 SHALL, on the start edge T0, capture both state shares into two independent 128-bit shift registers.
REQ-020 SHALL drive byte k (k=0..15) of each share on sbox_in0/1 during cycle T(k)..T(k+1), byte 0 first.
REQ-021 SHALL drive sbox_in0=sbox_in1=8'h00 in every cycle outside FEED.
REQ-022 SHALL track issued bytes with a SBOX_LAT-deep valid shift register; never infer validity from data.
REQ-023 SHALL capture sbox_out0/1 for byte k at edge T(k+SBOX_LAT+1) into byte k of the share-0/share-1 result registers respectively.
REQ-024 SHALL assert done for exactly one cycle after edge T(16+SBOX_LAT) (T21 at default) and drop busy at that edge.
REQ-025 SHALL hold state_out0/1 stable from done until the next completed operation.
REQ-026 SHALL never XOR, AND or mux share-0 signals with share-1 signals in any path (shares stay in separate registers/logic).
REQ-027 SHALL ignore start while busy; a start in the done cycle (FSM back in IDLE) SHALL be accepted.
REQ-028 SHALL implement a 32-bit right-shift Galois LFSR, feedback mask 32'h80200003 (x^32+x^22+x^2+x+1), advancing every cycle.
REQ-029 SHALL drive mask_out = lfsr[15:0] (registered, changes every cycle).
REQ-030 SHALL load seed on seed_load in IDLE, substituting 32'h00000001 for an all-zero seed; seed_load outside IDLE ignored.
REQ-031 SHALL, if seed_load and start coincide in IDLE, load the seed and start the operation in the same edge.

Reset
REQ-032 SHALL, on resetn=0, asynchronously clear FSM to IDLE, busy=0, done=0, sbox_in0/1=0, state_out0/1=0, all shift/valid registers=0, lfsr=32'h00000001.
REQ-033 SHALL, on reset mid-operation, abandon the operation with no done pulse; results from in-flight bytes SHALL be discarded.

Verification
REQ-034 SHALL verify: both shares all-zero, start -> done at T21, state_out0^state_out1 = 16 x 8'h63, busy high T0..T21.
REQ-035 SHALL verify: unmasked 0x00,0x01,0x53,... split with random share0 -> recombined output 0x63,0x7C,0xED,... per FIPS-197 table.
REQ-036 SHALL verify: start pulsed at T5 and T10 while busy -> single done at T21, result unchanged.
REQ-037 SHALL verify: back-to-back start in done cycle -> second done exactly 21 cycles later, both results correct.
REQ-038 SHALL verify: resetn low at T8 -> all outputs zero, no done, next start completes correctly.
REQ-039 SHALL verify: seed_load with seed=0 then 8 cycles -> mask_out matches golden LFSR from 32'h00000001; seed_load while busy has no effect.
